// File: rtl/note_pkg.sv
// Shared types and constants for the note hit judge.
package note_pkg;

  typedef logic [4:0] lane_t;

  localparam int unsigned LANE_G = 4;
  localparam int unsigned LANE_R = 3;
  localparam int unsigned LANE_Y = 2;
  localparam int unsigned LANE_B = 1;
  localparam int unsigned LANE_O = 0;

  localparam int unsigned STREAK_STEP = 10;
  localparam int unsigned MULT_MAX    = 4;

  typedef enum logic {
    J_IDLE  = 1'b0,
    J_ARMED = 1'b1
  } judge_state_t;

  // Score multiplier for a hit, from the streak held before that hit.
  function automatic logic [2:0] hit_mult(input logic [7:0] streak_now);
    logic [7:0] tier;
    tier = streak_now / 8'(STREAK_STEP);
    if (tier >= 8'(MULT_MAX - 1)) return 3'(MULT_MAX);
    return 3'(tier) + 3'd1;
  endfunction

endpackage

// File: rtl/note_hit_judge_if.sv
// Note-activation in, player input in, judgement results out.
interface note_hit_judge_if
  import note_pkg::*;
#(
  parameter int unsigned SCORE_W = 16
);
  logic               note_tick;
  logic               g_activate;
  logic               r_activate;
  logic               y_activate;
  logic               b_activate;
  logic               o_activate;
  lane_t              frets;
  logic               strum;
  logic               hit_pulse;
  logic               miss_pulse;
  logic [SCORE_W-1:0] score;
  logic [7:0]         streak;
  lane_t              lane_due;

  modport master (
    output note_tick, g_activate, r_activate, y_activate, b_activate, o_activate, frets, strum,
    input  hit_pulse, miss_pulse, score, streak, lane_due
  );

  modport slave (
    input  note_tick, g_activate, r_activate, y_activate, b_activate, o_activate, frets, strum,
    output hit_pulse, miss_pulse, score, streak, lane_due
  );
endinterface

// File: rtl/note_tick_sync.sv
// Two-flop synchronizer plus rising-edge detect for a slow strobe from another clock domain.
module note_tick_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic evt_c
);
  logic [2:0] sync_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_in};
  end

  assign evt_c = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/note_hit_judge.sv
// Delays note lane vectors by the highway travel time and judges strums against them.
// Build option: OVERSTRUM_PENALTY_EN makes a strum with no note due count as a miss.
module note_hit_judge
  import note_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = 8,
  parameter int unsigned WINDOW_CYC   = 4_000_000,
  parameter int unsigned SCORE_W      = 16
) (
  input logic             CLK,
  input logic             RESET,
  note_hit_judge_if.slave bus
);
  localparam int unsigned Q_W   = TRAVEL_TICKS * 5;
  localparam int unsigned WIN_W = $clog2(WINDOW_CYC);
  localparam int unsigned SUM_W = SCORE_W + 1;

  logic               tick_evt_c;
  lane_t              lanes_c;
  lane_t              head_c;
  logic [Q_W-1:0]     queue_q;
  logic [Q_W-1:0]     queue_shift_c;

  judge_state_t       state_q, state_d;
  lane_t              lane_due_q, lane_due_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         streak_q, streak_d;
  logic               load_ok, judged, hit_now;
  logic [SUM_W-1:0]   sum_c;

  note_tick_sync u_tick_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (bus.note_tick),
    .evt_c    (tick_evt_c)
  );

  always_comb begin
    lanes_c         = '0;
    lanes_c[LANE_G] = bus.g_activate;
    lanes_c[LANE_R] = bus.r_activate;
    lanes_c[LANE_Y] = bus.y_activate;
    lanes_c[LANE_B] = bus.b_activate;
    lanes_c[LANE_O] = bus.o_activate;
  end

  generate
    if (TRAVEL_TICKS == 1) begin : g_q1
      assign queue_shift_c = lanes_c;
    end else begin : g_qn
      assign queue_shift_c = {queue_q[Q_W-6:0], lanes_c};
    end
  endgenerate

  assign head_c = queue_q[Q_W-1 -: 5];

  // Travel-time delay line, advanced once per note tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)           queue_q <= '0;
    else if (tick_evt_c) queue_q <= queue_shift_c;
  end

  assign sum_c = {1'b0, score_q} + SUM_W'(hit_mult(streak_q));

  always_comb begin
    state_d    = state_q;
    lane_due_d = lane_due_q;
    win_d      = win_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    streak_d   = streak_q;
    judged     = 1'b0;
    hit_now    = 1'b0;
    load_ok    = tick_evt_c && (head_c != '0);

    unique case (state_q)
      J_IDLE: begin
`ifdef OVERSTRUM_PENALTY_EN
        if (bus.strum) begin
          miss_d   = 1'b1;
          streak_d = '0;
        end
`endif
        if (load_ok) begin
          state_d    = J_ARMED;
          lane_due_d = head_c;
          win_d      = WIN_W'(WINDOW_CYC - 1);
        end
      end
      J_ARMED: begin
        // Old note is always judged before a newly arriving head is loaded.
        if (bus.strum) begin
          judged  = 1'b1;
          hit_now = (bus.frets == lane_due_q);
        end else if (load_ok || (win_q == '0)) begin
          judged = 1'b1;
        end else begin
          win_d = win_q - WIN_W'(1);
        end

        if (judged) begin
          if (hit_now) begin
            hit_d    = 1'b1;
            score_d  = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
            streak_d = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
          end else begin
            miss_d   = 1'b1;
            streak_d = '0;
          end
          state_d    = J_IDLE;
          lane_due_d = '0;
          if (load_ok) begin
            state_d    = J_ARMED;
            lane_due_d = head_c;
            win_d      = WIN_W'(WINDOW_CYC - 1);
          end
        end
      end
      default: state_d = J_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= J_IDLE;
      lane_due_q <= '0;
      win_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      lane_due_q <= lane_due_d;
      win_q      <= win_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      streak_q   <= streak_d;
    end
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.score      = score_q;
  assign bus.streak     = streak_q;
  assign bus.lane_due   = lane_due_q;
endmodule

// File: tb/tb_note_hit_judge.sv
// Directed bench for note_hit_judge: hit, wrong frets, timeout, multiplier, supersede, overstrum, reset.
module tb_note_hit_judge;
  import note_pkg::*;

  localparam int unsigned TRAVEL_TICKS = 4;
  localparam int unsigned WINDOW_CYC   = 16;
  localparam int unsigned SCORE_W      = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  note_hit_judge_if #(.SCORE_W(SCORE_W)) bus ();

  note_hit_judge #(
    .TRAVEL_TICKS (TRAVEL_TICKS),
    .WINDOW_CYC   (WINDOW_CYC),
    .SCORE_W      (SCORE_W)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hit_seen = 0;
  int miss_seen = 0;
  int both_seen = 0;

  lane_t pats [12] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00011,
                       5'b00110, 5'b01100, 5'b11000, 5'b10101, 5'b01010, 5'b11111};
  lane_t seq5 [4]  = '{5'b10001, 5'b01110, 5'b00111, 5'b11100};

  always @(negedge CLK) begin
    if (bus.hit_pulse === 1'b1)  hit_seen++;
    if (bus.miss_pulse === 1'b1) miss_seen++;
    if (bus.hit_pulse === 1'b1 && bus.miss_pulse === 1'b1) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic tick_begin(input lane_t l);
    {bus.g_activate, bus.r_activate, bus.y_activate, bus.b_activate, bus.o_activate} = l;
    bus.note_tick = 1'b1;
  endtask

  task automatic tick_finish();
    steps(20);
    bus.note_tick = 1'b0;
    steps(20);
  endtask

  task automatic tick_full(input lane_t l);
    tick_begin(l);
    tick_finish();
  endtask

  task automatic wait_due(input lane_t exp);
    for (int i = 0; i < 10 && bus.lane_due !== exp; i++) step();
    chk("lane_due_load", 32'(bus.lane_due), 32'(exp));
  endtask

  // Queue a note and run ticks until it reaches the strike line; leaves the tick high.
  task automatic arm_note(input lane_t l);
    tick_full(l);
    repeat (TRAVEL_TICKS - 1) tick_full('0);
    tick_begin('0);
    wait_due(l);
  endtask

  task automatic strum_once(input lane_t f);
    bus.frets = f;
    bus.strum = 1'b1;
    step();
    bus.strum = 1'b0;
  endtask

  task automatic hit_run(input int n);
    for (int t = 0; t < n + 4; t++) begin
      tick_begin((t < n) ? pats[t] : 5'b00000);
      if (t >= 4) begin
        wait_due(pats[t-4]);
        steps(3);
        strum_once(pats[t-4]);
        chk("run_hit_pulse", 32'(bus.hit_pulse), 32'd1);
      end
      tick_finish();
    end
  endtask

  task automatic do_reset();
    bus.note_tick = 1'b0;
    bus.strum     = 1'b0;
    RESET = 1'b1;
    steps(2);
    RESET = 1'b0;
    step();
  endtask

  int h0, m0, n;

  initial begin
    RESET = 1'b1;
    bus.note_tick = 1'b0;
    bus.strum = 1'b0;
    bus.frets = '0;
    tick_begin('0);
    bus.note_tick = 1'b0;
    steps(3);
    chk("rst_lane_due", 32'(bus.lane_due), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_streak", 32'(bus.streak), 32'd0);
    chk("rst_hit", 32'(bus.hit_pulse), 32'd0);
    chk("rst_miss", 32'(bus.miss_pulse), 32'd0);
    RESET = 1'b0;
    step();

    // Correct strum on a due note.
    arm_note(5'b00100);
    steps(3);
    strum_once(5'b00100);
    chk("t1_hit", 32'(bus.hit_pulse), 32'd1);
    chk("t1_score", 32'(bus.score), 32'd1);
    chk("t1_streak", 32'(bus.streak), 32'd1);
    chk("t1_due_clear", 32'(bus.lane_due), 32'd0);
    step();
    chk("t1_hit_width", 32'(bus.hit_pulse), 32'd0);
    tick_finish();

    // Extra fret held: miss, streak cleared, score kept.
    h0 = hit_seen; m0 = miss_seen;
    arm_note(5'b00100);
    steps(3);
    strum_once(5'b00110);
    chk("t2_miss", 32'(bus.miss_pulse), 32'd1);
    chk("t2_streak", 32'(bus.streak), 32'd0);
    chk("t2_score", 32'(bus.score), 32'd1);
    chk("t2_due_clear", 32'(bus.lane_due), 32'd0);
    tick_finish();
    chk("t2_miss_count", 32'(miss_seen - m0), 32'd1);
    chk("t2_no_hit", 32'(hit_seen - h0), 32'd0);

    // Timeout: lane_due appears one CLK after tick_evt, miss 16 CLK after that (17 after tick_evt).
    do_reset();
    m0 = miss_seen;
    arm_note(5'b01000);
    n = 0;
    while (bus.miss_pulse !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t3_timeout_lat", 32'(n), 32'd16);
    chk("t3_due_clear", 32'(bus.lane_due), 32'd0);
    tick_finish();
    chk("t3_miss_count", 32'(miss_seen - m0), 32'd1);

    // Multiplier steps up after 10 hits: 10*1 + 2*2.
    do_reset();
    hit_run(12);
    chk("t4_score", 32'(bus.score), 32'd14);
    chk("t4_streak", 32'(bus.streak), 32'd12);
    arm_note(5'b01000);
    steps(3);
    strum_once(5'b00001);
    chk("t4_miss", 32'(bus.miss_pulse), 32'd1);
    chk("t4_streak_clr", 32'(bus.streak), 32'd0);
    chk("t4_score_kept", 32'(bus.score), 32'd14);
    tick_finish();

    // Fast ticks, never strum: each new head supersedes the previous note.
    do_reset();
    m0 = miss_seen;
    for (int j = 0; j < 4; j++) tick_full(seq5[j]);
    for (int j = 0; j < 4; j++) begin
      tick_begin('0);
      wait_due(seq5[j]);
      steps(3);
      bus.note_tick = 1'b0;
      steps(5);
    end
    chk("t5_superseded", 32'(miss_seen - m0), 32'd3);
    steps(30);
    chk("t5_final_timeout", 32'(miss_seen - m0), 32'd4);
    chk("t5_due_clear", 32'(bus.lane_due), 32'd0);

    // Strum with nothing due.
    do_reset();
    hit_run(5);
    chk("t6_streak5", 32'(bus.streak), 32'd5);
    chk("t6_score5", 32'(bus.score), 32'd5);
    steps(2);
    strum_once(5'b00100);
`ifdef OVERSTRUM_PENALTY_EN
    chk("t6_overstrum_miss", 32'(bus.miss_pulse), 32'd1);
    chk("t6_overstrum_streak", 32'(bus.streak), 32'd0);
`else
    chk("t6_overstrum_miss", 32'(bus.miss_pulse), 32'd0);
    chk("t6_overstrum_streak", 32'(bus.streak), 32'd5);
`endif
    chk("t6_overstrum_score", 32'(bus.score), 32'd5);
    step();

    // Reset in the middle of an open window.
    arm_note(5'b00010);
    steps(2);
    RESET = 1'b1;
    #1;
    chk("t6_rst_due", 32'(bus.lane_due), 32'd0);
    chk("t6_rst_score", 32'(bus.score), 32'd0);
    chk("t6_rst_streak", 32'(bus.streak), 32'd0);
    chk("t6_rst_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 32'd0);
    bus.note_tick = 1'b0;
    steps(3);
    RESET = 1'b0;
    h0 = hit_seen; m0 = miss_seen;
    steps(40);
    chk("t6_post_rst_pulses", 32'((hit_seen - h0) + (miss_seen - m0)), 32'd0);
    chk("t6_post_rst_due", 32'(bus.lane_due), 32'd0);

    chk("never_both_pulses", 32'(both_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
